mem_access_stage: RTL and testbench

- MEM-stage load/store unit between the EX/MEM register and the MEM/WB register.
- Takes the ALU-computed address and store data, runs a req/ack transaction on the data-memory bus, and aligns and extends load data into readDataM for MEM/WB.
- Stalls the pipeline while a transaction is outstanding.
- Flags misaligned accesses, illegal sizes and bus timeouts.

---
 rtl/mem_access_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: issues one req/ack data-memory transaction per
// load or store, stalls the pipeline while it is outstanding, aligns and
// extends load data, and flags misaligned/illegal accesses and bus timeouts.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [1:0]  memSizeM,
  input  logic        memSignedM,
  input  logic [31:0] aluOutM,
  input  logic [31:0] writeDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        addrErrM,
  output logic        busErrM
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic [1:0]     size_r;
  logic           signed_r;
  logic [1:0]     off_r;
  logic           is_load_r;
  logic           mem_op_s;
  logic           access_s;
  logic           addr_err_s;
  logic           stall_s;

  // Byte-lane enables for a given size and byte offset.
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across every lane of its size.
  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Little-endian lane extraction followed by sign or zero extension.
  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [31:0] sh;
    logic [31:0] d;
    case (size)
      2'b00: begin
        sh = rdata >> {off, 3'b000};
        d  = {{24{sgn & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = rdata >> {off[1], 4'b0000};
        d  = {{16{sgn & sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = rdata;
        d  = rdata;
      end
    endcase
    return d;
  endfunction

  assign mem_op_s = memReadM | memWriteM;
  assign access_s = mem_op_s & ~addr_err_s;
  assign addrErrM = addr_err_s;
  assign stallM   = stall_s;

  // Alignment and size legality check of the access currently in MEM.
  always_comb begin
    addr_err_s = 1'b0;
    if (mem_op_s) begin
      addr_err_s = (memSizeM == 2'b11) ||
                   ((memSizeM == 2'b01) && aluOutM[0]) ||
                   ((memSizeM == 2'b10) && (aluOutM[1:0] != 2'b00));
    end else begin
      addr_err_s = 1'b0;
    end
  end

  // Pipeline stall: held from the issuing IDLE cycle through REQ, released in DONE.
  always_comb begin
    stall_s = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    stall_s = access_s;
        REQ:     stall_s = 1'b1;
        DONE:    stall_s = 1'b0;
        default: stall_s = 1'b0;
      endcase
    end
  end

  // Transaction FSM with registered bus-side and pipeline-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      off_r      <= 2'b00;
      is_load_r  <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h0000_0000;
      readDataM  <= 32'h0000_0000;
      busErrM    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busErrM <= 1'b0;
          if (access_s) begin
            dmem_req   <= 1'b1;
            // A load takes priority if both strobes are ever set.
            dmem_we    <= ~memReadM & memWriteM;
            dmem_addr  <= {aluOutM[31:2], 2'b00};
            dmem_be    <= calc_be(memSizeM, aluOutM[1:0]);
            dmem_wdata <= calc_wdata(memSizeM, writeDataM);
            size_r     <= memSizeM;
            signed_r   <= memSignedM;
            off_r      <= aluOutM[1:0];
            is_load_r  <= memReadM;
            cnt_r      <= '0;
            state_r    <= REQ;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            // An ack coinciding with the last allowed cycle still completes cleanly.
            dmem_req <= 1'b0;
            if (is_load_r) begin
              readDataM <= extract(dmem_rdata, size_r, off_r, signed_r);
            end
            state_r <= DONE;
          end else if (cnt_r == CNT_LAST) begin
            dmem_req  <= 1'b0;
            busErrM   <= 1'b1;
            readDataM <= 32'h0000_0000;
            state_r   <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          busErrM <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          dmem_req <= 1'b0;
          busErrM  <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expected values.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        memReadM;
  logic        memWriteM;
  logic [1:0]  memSizeM;
  logic        memSignedM;
  logic [31:0] aluOutM;
  logic [31:0] writeDataM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] readDataM;
  logic        stallM;
  logic        addrErrM;
  logic        busErrM;

  int vec_cnt;
  int err_cnt;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .memReadM(memReadM), .memWriteM(memWriteM), .memSizeM(memSizeM),
    .memSignedM(memSignedM), .aluOutM(aluOutM), .writeDataM(writeDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .readDataM(readDataM), .stallM(stallM),
    .addrErrM(addrErrM), .busErrM(busErrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    memReadM   = rd;
    memWriteM  = wr;
    memSizeM   = sz;
    memSignedM = sg;
    aluOutM    = a;
    writeDataM = wd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    tick();
    tick();
    vec_cnt++; if (stallM !== 1'b0) begin err_cnt++; $display("FAIL reset_stall got=%b exp=0", stallM); end
    vec_cnt++; if ({dmem_req, dmem_we, dmem_be} !== 6'b0) begin err_cnt++; $display("FAIL reset_ctl got=%b%b%b exp=0", dmem_req, dmem_we, dmem_be); end
    vec_cnt++; if ({dmem_addr, dmem_wdata, readDataM} !== 96'h0) begin err_cnt++; $display("FAIL reset_data addr=%h wdata=%h rd=%h exp=0", dmem_addr, dmem_wdata, readDataM); end
    vec_cnt++; if (busErrM !== 1'b0) begin err_cnt++; $display("FAIL reset_buserr got=%b exp=0", busErrM); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word_load();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    vec_cnt++; if (stallM !== 1'b1 || addrErrM !== 1'b0 || dmem_req !== 1'b0) begin err_cnt++; $display("FAIL wl_idle stall=%b aerr=%b req=%b exp=1,0,0", stallM, addrErrM, dmem_req); end
    tick();
    vec_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || stallM !== 1'b1) begin err_cnt++; $display("FAIL wl_req req=%b we=%b stall=%b exp=1,0,1", dmem_req, dmem_we, stallM); end
    vec_cnt++; if (dmem_be !== 4'b1111 || dmem_addr !== 32'h0000_0100) begin err_cnt++; $display("FAIL wl_be be=%b addr=%h exp=1111 00000100", dmem_be, dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    vec_cnt++; if (dmem_req !== 1'b0 || stallM !== 1'b0) begin err_cnt++; $display("FAIL wl_done req=%b stall=%b exp=0,0", dmem_req, stallM); end
    vec_cnt++; if (readDataM !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL wl_data got=%h exp=deadbeef", readDataM); end
    tick();
  endtask

  task automatic load_once(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_data, input string name);
    drive(1'b1, 1'b0, sz, sg, a, 32'h0);
    tick();
    vec_cnt++; if (dmem_be !== exp_be || dmem_addr !== {a[31:2], 2'b00}) begin err_cnt++; $display("FAIL %s_be be=%b addr=%h exp=%b %h", name, dmem_be, dmem_addr, exp_be, {a[31:2], 2'b00}); end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    vec_cnt++; if (readDataM !== exp_data) begin err_cnt++; $display("FAIL %s_data got=%h exp=%h", name, readDataM, exp_data); end
    tick();
  endtask

  task automatic test_sub_word_loads();
    load_once(2'b00, 1'b1, 32'h0000_0103, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80, "lb_s");
    load_once(2'b01, 1'b1, 32'h0000_0102, 32'h8001_1234, 4'b1100, 32'hFFFF_8001, "lh_s");
    load_once(2'b00, 1'b0, 32'h0000_0101, 32'h0000_F100, 4'b0010, 32'h0000_00F1, "lb_u1");
    load_once(2'b00, 1'b0, 32'h0000_0103, 32'h8012_3456, 4'b1000, 32'h0000_0080, "lb_u");
  endtask

  task automatic test_stores();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD);
    vec_cnt++; if (stallM !== 1'b1) begin err_cnt++; $display("FAIL sh_stall got=%b exp=1", stallM); end
    tick();
    vec_cnt++; if (dmem_we !== 1'b1 || dmem_be !== 4'b1100) begin err_cnt++; $display("FAIL sh_ctl we=%b be=%b exp=1 1100", dmem_we, dmem_be); end
    vec_cnt++; if (dmem_wdata !== 32'hABCD_ABCD || dmem_addr !== 32'h0000_0100) begin err_cnt++; $display("FAIL sh_data wdata=%h addr=%h exp=abcdabcd 00000100", dmem_wdata, dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    vec_cnt++; if (readDataM !== 32'h0000_0080) begin err_cnt++; $display("FAIL sh_rdhold got=%h exp=00000080", readDataM); end
    tick();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_565A);
    tick();
    vec_cnt++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'h5A5A_5A5A) begin err_cnt++; $display("FAIL sb_ctl be=%b wdata=%h exp=0010 5a5a5a5a", dmem_be, dmem_wdata); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_addr_err();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
    vec_cnt++; if (addrErrM !== 1'b1 || stallM !== 1'b0) begin err_cnt++; $display("FAIL mis_word aerr=%b stall=%b exp=1,0", addrErrM, stallM); end
    tick();
    vec_cnt++; if (dmem_req !== 1'b0) begin err_cnt++; $display("FAIL mis_req got=%b exp=0", dmem_req); end
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h0);
    vec_cnt++; if (addrErrM !== 1'b1) begin err_cnt++; $display("FAIL mis_half got=%b exp=1", addrErrM); end
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
    vec_cnt++; if (addrErrM !== 1'b1 || stallM !== 1'b0) begin err_cnt++; $display("FAIL ill_size aerr=%b stall=%b exp=1,0", addrErrM, stallM); end
    drive(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0101, 32'h0);
    vec_cnt++; if (addrErrM !== 1'b0) begin err_cnt++; $display("FAIL noop_aerr got=%b exp=0", addrErrM); end
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles;
    req_cycles = 0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      if (dmem_req === 1'b1 && stallM === 1'b1 && busErrM === 1'b0) req_cycles++;
      tick();
    end
    vec_cnt++; if (req_cycles !== 16) begin err_cnt++; $display("FAIL to_reqlen got=%0d exp=16", req_cycles); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    vec_cnt++; if (dmem_req !== 1'b0 || busErrM !== 1'b1 || stallM !== 1'b0) begin err_cnt++; $display("FAIL to_done req=%b berr=%b stall=%b exp=0,1,0", dmem_req, busErrM, stallM); end
    vec_cnt++; if (readDataM !== 32'h0) begin err_cnt++; $display("FAIL to_data got=%h exp=00000000", readDataM); end
    tick();
    vec_cnt++; if (busErrM !== 1'b0) begin err_cnt++; $display("FAIL to_pulse got=%b exp=0", busErrM); end
    // Ack in the final allowed REQ cycle completes without error.
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    vec_cnt++; if (dmem_req !== 1'b1) begin err_cnt++; $display("FAIL tl_req got=%b exp=1", dmem_req); end
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    vec_cnt++; if (busErrM !== 1'b0 || dmem_req !== 1'b0) begin err_cnt++; $display("FAIL tl_done berr=%b req=%b exp=0,0", busErrM, dmem_req); end
    vec_cnt++; if (readDataM !== 32'h1234_5678) begin err_cnt++; $display("FAIL tl_data got=%h exp=12345678", readDataM); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    tick();
    tick();
    vec_cnt++; if (dmem_req !== 1'b1) begin err_cnt++; $display("FAIL rm_req2 got=%b exp=1", dmem_req); end
    rst = 1'b1;
    #1;
    vec_cnt++; if (stallM !== 1'b0) begin err_cnt++; $display("FAIL rm_stall got=%b exp=0", stallM); end
    tick();
    vec_cnt++; if (dmem_req !== 1'b0 || readDataM !== 32'h0 || dmem_addr !== 32'h0) begin err_cnt++; $display("FAIL rm_rst req=%b rd=%h addr=%h exp=0", dmem_req, readDataM, dmem_addr); end
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0;
    #1;
    vec_cnt++; if (dmem_req !== 1'b0 || readDataM !== 32'h0 || busErrM !== 1'b0 || stallM !== 1'b0) begin err_cnt++; $display("FAIL rm_late req=%b rd=%h berr=%b stall=%b exp=0", dmem_req, readDataM, busErrM, stallM); end
    // Fresh access after reset still works.
    load_once(2'b10, 1'b0, 32'h0000_0304, 32'h0BAD_C0DE, 4'b1111, 32'h0BAD_C0DE, "post_rst");
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_word_load();
    test_sub_word_loads();
    test_stores();
    test_addr_err();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
